// File: rtl/shift_deser_if.sv
// Bundle of the serial-input and parallel-output signals of the shift_deser receiver.
// master: the side that drives serial bits and consumes words. slave: the receiver.
interface shift_deser_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
);
   logic             enable;
   logic             serial_in;
   logic             serial_valid;
   logic             msb_first;
   logic             clear;
   logic             data_ready;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             overrun;
   logic [CNT_W-1:0] bit_count;

   modport master (
      output enable, serial_in, serial_valid, msb_first, clear, data_ready,
      input  data_out, data_valid, overrun, bit_count
   );

   modport slave (
      input  enable, serial_in, serial_valid, msb_first, clear, data_ready,
      output data_out, data_valid, overrun, bit_count
   );
endinterface

// File: rtl/shift_deser.sv
// Serial-in, parallel-out receiver: assembles WIDTH-bit words one bit per accepted
// cycle (MSB- or LSB-first, order latched at the first bit) and presents each word
// on a held output with a valid/ready handshake and a sticky overrun flag.
module shift_deser #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic           clk,
   input  logic           reset,
   shift_deser_if.slave   bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   state_t           state_q, state_d;
   logic             order_q, order_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dvalid_q, dvalid_d;
   logic             ovr_q, ovr_d;

   logic             accept_s;
   logic             order_s;
   logic [WIDTH-1:0] shifted_s;

   assign accept_s = bus.enable & bus.serial_valid & ~bus.clear;

   // Shift-register image after taking serial_in, using the order in force for this bit.
   always_comb begin
      order_s   = order_q;
      shifted_s = sr_q;
      if (state_q == ST_IDLE) begin
         order_s = bus.msb_first;
      end else begin
         order_s = order_q;
      end
      if (order_s) begin
         shifted_s = {sr_q[WIDTH-2:0], bus.serial_in};
      end else begin
         shifted_s = {bus.serial_in, sr_q[WIDTH-1:1]};
      end
   end

   // Next-state logic: bit assembly, word completion, holding stage and overrun.
   always_comb begin
      state_d  = state_q;
      order_d  = order_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      dvalid_d = dvalid_q;
      ovr_d    = ovr_q;

      // Consumer handshake is independent of enable and clear.
      if (dvalid_q && bus.data_ready) begin
         dvalid_d = 1'b0;
      end else begin
         dvalid_d = dvalid_q;
      end

      if (bus.clear) begin
         // Abort the partial word; the holding stage is left alone.
         state_d = ST_IDLE;
         sr_d    = {WIDTH{1'b0}};
         cnt_d   = {CNT_W{1'b0}};
         ovr_d   = 1'b0;
      end else if (accept_s) begin
         case (state_q)
            ST_IDLE: begin
               order_d = bus.msb_first;
               sr_d    = shifted_s;
               cnt_d   = ONE_CNT;
               state_d = ST_RECV;
            end
            ST_RECV: begin
               sr_d = shifted_s;
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = {CNT_W{1'b0}};
                  state_d = ST_IDLE;
                  // A word may load if the stage is empty or drains this same cycle.
                  if (!dvalid_q || bus.data_ready) begin
                     dout_d   = shifted_s;
                     dvalid_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + ONE_CNT;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end
         endcase
      end else begin
         // No accepted bit: partial word stays frozen.
         state_d = state_q;
         cnt_d   = cnt_q;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         order_q  <= 1'b0;
         sr_q     <= {WIDTH{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         dout_q   <= {WIDTH{1'b0}};
         dvalid_q <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         order_q  <= order_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         ovr_q    <= ovr_d;
      end
   end

   assign bus.data_out   = dout_q;
   assign bus.data_valid = dvalid_q;
   assign bus.overrun    = ovr_q;
   assign bus.bit_count  = cnt_q;

endmodule
